// File: rtl/cpu_control_unit.sv
// Hardwired Moore control sequencer for the single-bus CPU datapath: fetch,
// opcode decode of IR[31:27] and per-step datapath strobes, plus run/halt status.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RESET | held in reset, all strobes low, Run low
// S_T0    | fetch: PC -> MAR, PC+1 -> Z
// S_T1    | fetch: Z -> PC, memory read into MDR
// S_T2    | fetch: MDR -> IR; nop completes, halt/undefined go to S_HALT
// S_T3-T7 | execute steps, sequence chosen by opcode
// S_HALT  | stopped, only clear exits
module cpu_control_unit #(
    parameter logic [4:0] INC_OP = 5'b11111,
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  operation,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIout,
    output logic        LOout,
    output logic        MDRout,
    output logic        In_Portout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin_low,
    output logic        Zin_high,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        outPortenable,
    output logic        ConIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] opc;
    logic [4:0] imm_op;
    logic       done;
    logic       is_alu, is_unary, is_imm, is_ld, is_ldi, is_st, is_md;
    logic       is_br, is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt;
    logic       unused_ir;

    assign opc       = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign is_alu   = (opc >= 5'b00011) && (opc <= 5'b01011);
    assign is_unary = (opc == 5'b10001) || (opc == 5'b10010);
    assign is_imm   = (opc >= 5'b01100) && (opc <= 5'b01110);
    assign is_ld    = (opc == 5'b00000);
    assign is_ldi   = (opc == 5'b00001);
    assign is_st    = (opc == 5'b00010);
    assign is_md    = (opc == 5'b01111) || (opc == 5'b10000);
    assign is_br    = (opc == 5'b10011);
    assign is_jr    = (opc == 5'b10100);
    assign is_jal   = (opc == 5'b10101);
    assign is_in    = (opc == 5'b10110);
    assign is_out   = (opc == 5'b10111);
    assign is_mfhi  = (opc == 5'b11000);
    assign is_mflo  = (opc == 5'b11001);
    assign is_nop   = (opc == 5'b11010);
    assign is_halt  = (opc >= 5'b11011);

    // addi/andi/ori reuse the add/and/or ALU codes
    assign imm_op = (opc == 5'b01100) ? 5'b00011 :
                    (opc == 5'b01101) ? 5'b00101 : 5'b00110;

    assign Run = (state != S_RESET) && (state != S_HALT);

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state <= S_RESET;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        done          = 1'b0;
        operation     = 5'b00000;
        PCout         = 1'b0;
        Zlowout       = 1'b0;
        Zhighout      = 1'b0;
        HIout         = 1'b0;
        LOout         = 1'b0;
        MDRout        = 1'b0;
        In_Portout    = 1'b0;
        Cout          = 1'b0;
        BAout         = 1'b0;
        Rout          = 1'b0;
        PCin          = 1'b0;
        IRin          = 1'b0;
        MARin         = 1'b0;
        MDRin         = 1'b0;
        Yin           = 1'b0;
        Zin_low       = 1'b0;
        Zin_high      = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        Rin           = 1'b0;
        outPortenable = 1'b0;
        ConIn         = 1'b0;
        Gra           = 1'b0;
        Grb           = 1'b0;
        Grc           = 1'b0;
        IncPC         = 1'b0;
        Read          = 1'b0;
        Write         = 1'b0;

        case (state)
            S_RESET: state_nxt = S_T0;
            S_HALT:  state_nxt = S_HALT;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1;
                operation = INC_OP;
                state_nxt = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_nxt = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                if (is_nop)       done = 1'b1;
                else if (is_halt) state_nxt = S_HALT;
                else              state_nxt = S_T3;
            end
            S_T3: begin
                state_nxt = S_T4;
                if (is_alu || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; Zin_low = 1'b1; operation = opc;
                end else if (is_ld || is_ldi || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_md) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
                end else if (is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; done = 1'b1;
                end else if (is_jal) begin
                    PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
                end else if (is_in) begin
                    In_Portout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end else if (is_out) begin
                    Gra = 1'b1; Rout = 1'b1; outPortenable = 1'b1; done = 1'b1;
                end else if (is_mfhi || is_mflo) begin
                    HIout = is_mfhi; LOout = is_mflo; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_T4: begin
                state_nxt = S_T5;
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin_low = 1'b1; operation = opc;
                end else if (is_unary) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin_low = 1'b1; operation = imm_op;
                end else if (is_ld || is_ldi || is_st) begin
                    Cout = 1'b1; Zin_low = 1'b1; operation = ADD_OP;
                end else if (is_md) begin
                    Grb = 1'b1; Rout = 1'b1; Zin_low = 1'b1; Zin_high = 1'b1; operation = opc;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (is_jal) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; done = 1'b1;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_T5: begin
                state_nxt = S_T6;
                if (is_alu || is_imm || is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_md) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin_low = 1'b1; operation = ADD_OP;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_T6: begin
                state_nxt = S_T7;
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_md) begin
                    Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
                end else if (is_br) begin
                    Zlowout = 1'b1; PCin = CON_FF; done = 1'b1;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1; done = 1'b1;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_HALT;
        endcase

        // Stop only takes effect at an instruction boundary
        if (done) state_nxt = Stop ? S_HALT : S_T0;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Hardwired control sequencer for the single-bus CPU datapath.
- Fetches each instruction, decodes IR[31:27], and drives all datapath strobes step by step (bus drivers, register loads, ALU op, memory read/write, port enables).
- Also provides run/halt status.
- Sits between the top-level CPU wrapper and the datapath; the only source of datapath control.

Parameters:
- INC_OP, 5'b11111, ALU operation code for PC+1 during fetch.
- ADD_OP, 5'b00011, ALU add code used for address/branch arithmetic.

Ports:
- Clock  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-low reset.
- IR  input  32  instruction register contents from datapath.
- CON_FF  input  1  branch condition flag from datapath.
- Stop  input  1  external halt request.
- Run  output  1  high while executing, low in reset/halt.
- operation  output  5  ALU operation select.
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, BAout, Rout  output  1 each  bus drivers.
- PCin, IRin, MARin, MDRin, Yin, Zin_low, Zin_high, HIin, LOin, Rin, outPortenable, ConIn  output  1 each  register loads.
- Gra, Grb, Grc  output  1 each  register-field selects for select/encode.
- IncPC, Read, Write  output  1 each  PC-increment and memory strobes.

Behaviour:
- Clock and reset: single clock `Clock`. `clear` low asynchronously forces state RESET and all outputs 0, including Run.
- Leaving reset: first rising edge after `clear` deasserts enters T0 with Run=1.
- State register: RESET, T0..T7, HALT. All outputs decode combinationally from registered state and IR[31:27] (Moore); no output depends on Stop or CON_FF combinationally, except PCin in branch T6.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin_low; operation=INC_OP.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute (T3 onward), by opcode:
  - R-type ALU ops (add 00011 … shl 01011, neg 10001, not 10010):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, operation=opcode, Zin_low.
    - T5: Zlowout, Gra, Rin. Done.
    - neg/not skip the Y load: T3 drives Grb, Rout, Zin_low.
  - Immediate ops (addi 01100, andi 01101, ori 01110):
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zin_low; operation=00011, 00101 or 00110 respectively.
    - T5: Zlowout, Gra, Rin.
  - ld 00000 / ldi 00001:
    - T3: Grb, BAout, Yin.
    - T4: Cout, ADD_OP, Zin_low.
    - T5: Zlowout, MARin.
    - ld: T6 Read, MDRin; T7 MDRout, Gra, Rin.
    - ldi: in T5 Zlowout instead loads Gra Rin, and the instruction ends.
  - st 00010:
    - T3–T5 as ld.
    - T6: Gra, Rout, MDRin.
    - T7: Write.
  - mul 10000 / div 01111:
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, operation=opcode, Zin_low, Zin_high.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - br 10011:
    - T3: Gra, Rout, ConIn.
    - T4: PCout, Yin.
    - T5: Cout, ADD_OP, Zin_low.
    - T6: Zlowout; PCin only if CON_FF=1.
  - jr 10100: T3 Gra, Rout, PCin.
  - jal 10101:
    - T3: PCout; Rin targets R15 via Grb with IR[22:19] fixed by assembler.
    - T4: Gra, Rout, PCin.
  - in 10110: T3 In_Portout, Gra, Rin.
  - out 10111: T3 Gra, Rout, outPortenable.
  - mfhi 11000 / mflo 11001: T3 HIout or LOout, Gra, Rin.
  - nop 11010: no execute steps; next state T0.
  - halt 11011 or any undefined opcode: enter HALT, Run=0, all strobes 0. Only reset exits.
- Instruction completion: after the last step of an instruction, the next state is T0. Step count per instruction is fixed as listed above.
- Stop: sampled only at instruction completion.
  - Stop=1 there → HALT instead of T0.
  - Stop asserted mid-instruction: the instruction finishes.
- Exclusivity: at most one bus-driver output is high in any state.
- Write and Read are never high in the same state.
- Reset mid-instruction aborts immediately; no partial register write occurs after `clear` falls.

Test Plan:
- Reset then release; IR=add R1,R2,R3 (0x18918000) → T0–T2 strobes as specified; T4 operation=00011; T5 Gra=Rin=1; back to T0 on cycle 7.
- ld R2,0x45(R1) → BAout in T3; Read+MDRin in T6; Rin in T7; 8 cycles total.
- br with CON_FF=0 vs 1 → PCin low vs high in T6; all other T6 outputs identical.
- mul → Zin_low and Zin_high both high in T4; LOin in T5; HIin in T6.
- halt opcode 11011 → Run falls the cycle after T2 and stays 0 for 20 cycles. Pulse `clear` low → Run=1 in T0.
- Stop raised during T4 of sub → sub completes through T5, then HALT, Run=0. Also assert `clear` low during T3 → all outputs 0 asynchronously.
